// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction encoding, FSM states and helpers for the snake direction path
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  typedef enum logic {
    ARMED  = 1'b0,
    LOCKED = 1'b1
  } fsm_state_t;

  // Opposite directions differ only in the upper encoding bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus stability counter for one push button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      // Any cycle of agreement restarts the count, so short glitches never land.
      if (r_s2 != r_stable) begin
        if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= r_s2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/dir_input_ctrl.sv
// rtl/dir_input_ctrl.sv - button debounce, press detect and one-turn-per-tick direction loader
// Optional DIR_PENDING_TURN_EN keeps one press made while locked and retries it after the tick.
module dir_input_ctrl
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn,
  input  logic [1:0] cur_dir,
  input  logic       tick,
  input  logic       run,
  output logic [1:0] dir_d,
  output logic       dir_load,
  output logic [3:0] btn_stable
);

  logic [3:0] w_stable;
  logic [3:0] r_stable_d;
  logic [3:0] r_press;
  fsm_state_t r_state;
  fsm_state_t w_state_nxt;
  dir_t       w_cand;
  logic       w_cand_vld;
  logic       w_cand_ok;
  logic       w_sel_vld;
  dir_t       w_sel_dir;
  logic       w_load_nxt;
  dir_t       w_d_nxt;
  logic       r_load;
  dir_t       r_dir_d;

  for (genvar g = 0; g < 4; g++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn[g]),
      .o_stable(w_stable[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_d <= '0;
      r_press    <= '0;
    end else begin
      r_stable_d <= w_stable;
      r_press    <= w_stable & ~r_stable_d;
    end
  end

  always_comb begin
    w_cand_vld = |r_press;
    if (r_press[0])      w_cand = DIR_UP;
    else if (r_press[1]) w_cand = DIR_RIGHT;
    else if (r_press[2]) w_cand = DIR_DOWN;
    else                 w_cand = DIR_LEFT;
    w_cand_ok = w_cand_vld && (w_cand != cur_dir) && !is_reverse(w_cand, cur_dir);
  end

`ifdef DIR_PENDING_TURN_EN
  logic r_pend_vld;
  dir_t r_pend_dir;
  logic w_pend_ok;

  assign w_pend_ok = r_pend_vld && (r_pend_dir != cur_dir) && !is_reverse(r_pend_dir, cur_dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld <= 1'b0;
      r_pend_dir <= DIR_UP;
    end else if (!run) begin
      r_pend_vld <= 1'b0;
    end else if (r_state == LOCKED) begin
      if (w_cand_vld) begin
        r_pend_vld <= 1'b1;
        r_pend_dir <= w_cand;
      end
    end else begin
      r_pend_vld <= 1'b0;
    end
  end

  always_comb begin
    if (w_pend_ok) begin
      w_sel_vld = 1'b1;
      w_sel_dir = r_pend_dir;
    end else begin
      w_sel_vld = w_cand_ok;
      w_sel_dir = w_cand;
    end
  end
`else
  always_comb begin
    w_sel_vld = w_cand_ok;
    w_sel_dir = w_cand;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ARMED;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARMED:   if (run && w_sel_vld) w_state_nxt = LOCKED;
      LOCKED:  if (!run || tick)     w_state_nxt = ARMED;
      default: w_state_nxt = ARMED;
    endcase
  end

  always_comb begin
    w_load_nxt = (r_state == ARMED) && run && w_sel_vld;
    w_d_nxt    = w_load_nxt ? w_sel_dir : r_dir_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load  <= 1'b0;
      r_dir_d <= DIR_UP;
    end else begin
      r_load  <= w_load_nxt;
      r_dir_d <= w_d_nxt;
    end
  end

  assign dir_d      = r_dir_d;
  assign dir_load   = r_load;
  assign btn_stable = w_stable;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// tb/tb_dir_input_ctrl.sv - scoreboard bench for dir_input_ctrl with DEBOUNCE_CYCLES=4
module tb_dir_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0;
  logic [1:0] cur_dir = 2'b00;
  logic       tick = 1'b0;
  logic       run = 1'b0;
  logic [1:0] dir_d;
  logic       dir_load;
  logic [3:0] btn_stable;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [1:0] d;
    int         at_edge;
  } exp_t;
  exp_t exp_q[$];

  dir_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .cur_dir   (cur_dir),
    .tick      (tick),
    .run       (run),
    .dir_d     (dir_d),
    .dir_load  (dir_load),
    .btn_stable(btn_stable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every load strobe must match the oldest expected load.
  always @(negedge clk) begin
    if (dir_load) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load_dir", int'(dir_d), -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("load_dir", int'(dir_d), int'(e.d));
        if (e.at_edge >= 0) chk("load_edge", edge_cnt, e.at_edge);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_load(input logic [1:0] d, input bit timed);
    exp_t e;
    e.d = d;
    e.at_edge = timed ? edge_cnt + 8 : -1;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [3:0] mask);
    btn = mask;
    cyc(12);
    btn = 4'b0;
    cyc(12);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(2);
  endtask

  initial begin
    int bad;
    cyc(2);
    chk("reset_dir_d", int'(dir_d), 0);
    chk("reset_dir_load", int'(dir_load), 0);
    chk("reset_btn_stable", int'(btn_stable), 0);
    rst_n = 1'b1;
    run = 1'b1;
    cyc(2);

    // Right from up: timed load, then check the stable level while held.
    cur_dir = 2'b00;
    expect_load(2'b01, 1'b1);
    btn = 4'b0010;
    cyc(8);
    chk("btn_stable_right", int'(btn_stable[1]), 1);
    btn = 4'b0;
    cyc(12);
    cur_dir = 2'b01;
    pulse_tick();

    // Down accepted, then left while locked.
    expect_load(2'b10, 1'b0);
    press(4'b0100);
    cur_dir = 2'b10;
    press(4'b1000);
`ifdef DIR_PENDING_TURN_EN
    expect_load(2'b11, 1'b0);
`endif
    pulse_tick();
    cyc(4);
`ifdef DIR_PENDING_TURN_EN
    cur_dir = 2'b11;
    pulse_tick();
`endif
    chk("queue_after_locked", exp_q.size(), 0);

    // Reset mid-debounce: counter at 2 after edge 3 of a right press.
    cur_dir = 2'b00;
    btn = 4'b0010;
    cyc(4);
    rst_n = 1'b0;
    #1;
    chk("midrst_dir_d", int'(dir_d), 0);
    chk("midrst_dir_load", int'(dir_load), 0);
    chk("midrst_btn_stable", int'(btn_stable), 0);
    cyc(1);
    rst_n = 1'b1;
    expect_load(2'b01, 1'b1);
    cyc(12);
    btn = 4'b0;
    cyc(12);
    cur_dir = 2'b01;
    pulse_tick();

    // Reversal and no-op from up.
    cur_dir = 2'b00;
    pulse_tick();
    press(4'b0100);
    press(4'b0001);

    // Short glitch on left must never become stable.
    bad = 0;
    btn = 4'b1000;
    cyc(3);
    btn = 4'b0;
    for (int i = 0; i < 10; i++) begin
      if (btn_stable[3]) bad++;
      cyc(1);
    end
    chk("glitch_stable_cycles", bad, 0);

    // Up and left together from right: up wins.
    cur_dir = 2'b01;
    expect_load(2'b00, 1'b0);
    press(4'b1001);
    cur_dir = 2'b00;
    pulse_tick();

    // run=0 suppresses loads.
    run = 1'b0;
    press(4'b0010);
    run = 1'b1;
    cyc(2);

`ifdef DIR_PENDING_TURN_EN
    cur_dir = 2'b01;
    pulse_tick();
    expect_load(2'b10, 1'b0);
    press(4'b0100);
    expect_load(2'b00, 1'b0);
    press(4'b0001);
    pulse_tick();
    cyc(4);
`endif

    cyc(10);
    chk("queue_empty_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dir_input_ctrl.md
Name: dir_input_ctrl

Overview:
- Upstream stage of the 2-bit snake direction register (DataSize=2 parallel-load register).
- Synchronizes and debounces the four push buttons, then detects presses.
- Rejects 180-degree reversals and no-op turns; allows at most one turn per game tick.
- Drives the register's d and load inputs through dir_d and dir_load.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a button level is accepted (5 ms at 100 MHz); minimum 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- btn  in  4  raw buttons, asynchronous to clk; [0]=up, [1]=right, [2]=down, [3]=left; active high.
- cur_dir  in  2  current direction, taken from the register q output.
- tick  in  1  one-cycle game-step pulse from the game timer.
- run  in  1  1 = game active; 0 = turns suppressed.
- dir_d  out  2  new direction to the register d input.
- dir_load  out  1  one-cycle load strobe to the register load input.
- btn_stable  out  4  debounced button levels, for LEDs and debug.

Behaviour:
- Reset is asynchronous:
  - All synchronizer flops, stable levels, counters and outputs go to 0.
  - FSM goes to ARMED.
  - Reset mid-debounce discards the partial count.
- Direction encoding: 00 up, 01 right, 10 down, 11 left. The reverse of a direction is that direction XOR 2'b10.
- Synchronizer: two flops per button (s1, s2).
- Debounce, per button:
  - The counter increments each cycle that s2 != btn_stable.
  - The counter clears to 0 the cycle s2 == btn_stable, so a glitch shorter than DEBOUNCE_CYCLES is never accepted.
  - When the counter reaches DEBOUNCE_CYCLES-1 and s2 still differs, btn_stable <= s2 and the counter clears.
- Press event: btn_stable & ~btn_stable_d, one cycle wide. Releases generate nothing.
- Simultaneous presses: priority up > right > down > left; only the winner is considered.
- Candidate rejection: a candidate equal to cur_dir, or to the reverse of cur_dir, is dropped with no state change.
- FSM (registered outputs):
  - ARMED:
    - Accepted candidate with run=1: dir_d <= candidate, dir_load <= 1 for exactly one cycle, go to LOCKED.
    - Applies even if tick is high the same cycle.
  - LOCKED:
    - Presses are not loaded (see Optional Feature).
    - tick=1: go to ARMED. A press in that same cycle is not loaded.
  - run=0: forces ARMED and suppresses dir_load.
- dir_d holds its last value when dir_load=0.
- Latency: dir_load is high in the cycle after the (DEBOUNCE_CYCLES+3)th rising edge, counting the edge that first samples the new btn level as edge 0.

Optional Feature:
- Macro: DIR_PENDING_TURN_EN.
- Defined:
  - One-entry pending buffer (valid bit plus 2-bit direction).
  - A press arriving in LOCKED is stored; a newer press overwrites it.
  - In the cycle after tick returns the FSM to ARMED, the pending entry is re-checked against cur_dir at that time. If accepted it loads (dir_load=1, back to LOCKED); the buffer clears either way.
  - run=0 or reset clears the buffer.
- Undefined: presses in LOCKED are discarded; no buffer logic is present.

Decomposition:
- Shared package snake_pkg:
  - Direction typedef (dir_t, 2 bits) and constants DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b10, DIR_LEFT=2'b11.
  - FSM state enum {ARMED, LOCKED}.
  - Function is_reverse(a,b).
- Sub-module btn_debounce (one button: synchronizer, counter, stable output), instantiated four times.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then right held with cur_dir=00, run=1 -> dir_d=01 and dir_load=1 for one cycle, high in the cycle after edge 7; btn_stable[1]=1.
- cur_dir=01, down pressed -> dir_d=10, dir_load pulse; then left pressed before tick -> no load. Without DIR_PENDING_TURN_EN, still no load after tick.
- cur_dir=00, down pressed -> no dir_load (reversal). Up pressed -> no dir_load (no-op turn).
- 3-cycle btn[3] glitch -> btn_stable stays 0, no dir_load. Up and left pressed on the same cycle with cur_dir=01 -> dir_d=00.
- rst_n low for one cycle mid-debounce (counter=2) -> outputs 0 immediately, counter 0, FSM ARMED; the held button loads 7 edges after release of reset.
- With DIR_PENDING_TURN_EN, cur_dir=01, state LOCKED, up pressed then tick, cur_dir still 01 -> dir_load with dir_d=00 in the cycle after ARMED is re-entered.
